src_fifo_rd_sched: RTL

- Burst read scheduler for the 512-bit read side of the source FIFO (first-word-fall-through, `rd_count` in 512-bit words).
- Accepts a transfer command (N words) from the core sequencer.
- Waits until a full burst is resident in the FIFO, then drains it into a registered 512-bit valid/ready stream toward the processing unit.
- Reports completion or abort with a status word.

---
 rtl/src_fifo_rd_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/src_fifo_rd_sched.sv
// Burst read scheduler for the 512-bit FWFT source FIFO: waits until a whole burst is
// resident, streams it out through a registered valid/ready stage, then reports status.
module src_fifo_rd_sched #(
  parameter int BURST = 16,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [511:0]     fifo_q,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_rd_count,
  output logic             fifo_re,
  output logic [511:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             done_aborted,
  output logic [LEN_W-1:0] done_count
);

  localparam int CMP_W = (LEN_W > 32) ? LEN_W : 32;
  localparam logic [LEN_W-1:0] BURST_L = LEN_W'(BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] blen;
  logic [LEN_W-1:0] sent;
  logic [LEN_W-1:0] need;
  logic             count_ok;
  logic             slot_free;
  logic             accept;

  assign need      = (rem < BURST_L) ? rem : BURST_L;
  // Occupancy is unsigned 32-bit; widen both sides so LEN_W may differ from 32.
  assign count_ok  = CMP_W'(fifo_rd_count) >= CMP_W'(need);
  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    fifo_re    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = (cmd_len == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_next = S_DRAIN;
        end else if (count_ok) begin
          state_next = S_XFER;
        end
      end
      S_XFER: begin
        fifo_re = slot_free && !fifo_empty && (blen != '0) && !abort;
        if (abort) begin
          state_next = S_DRAIN;
        end else if (fifo_re && (blen == LEN_W'(1))) begin
          state_next = (rem == LEN_W'(1)) ? S_DRAIN : S_WAIT;
        end else if (blen == '0) begin
          state_next = (rem != '0) ? S_WAIT : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem          <= '0;
      blen         <= '0;
      sent         <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
      done_aborted <= 1'b0;
      done_count   <= '0;
    end else begin
      done <= 1'b0;

      // A pop refills the output slot in the same cycle the held word leaves.
      if (fifo_re) begin
        out_data  <= fifo_q;
        out_valid <= 1'b1;
        blen      <= blen - LEN_W'(1);
        rem       <= rem - LEN_W'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        sent <= sent + LEN_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rem  <= cmd_len;
            sent <= '0;
          end
        end
        S_WAIT: begin
          if (!abort && count_ok) begin
            blen <= need;
          end
        end
        S_DONE: begin
          done         <= 1'b1;
          done_aborted <= (rem != '0);
          done_count   <= sent;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
